// File: rtl/exagu_rev_pkg.sv
// exagu_rev_pkg: shared encodings for the reverse AGU (exagu_rev_index).
// Holds the scale encoding, the idUIxt field positions, the 16-bit slice
// width and the index scaling helpers used by the output stage.
package exagu_rev_pkg;

    localparam int SLICE_W        = 16;
    localparam int NUM_SLICES     = 3;
    localparam int INDEX_W        = SLICE_W * NUM_SLICES;
    localparam int UIXT_W         = 9;
    localparam int UIXT_ZEXT_BIT  = 2;
    localparam int UIXT_SCALE_LSB = 0;
    localparam int SCALE_W        = 2;

    // Element size encoded as log2(bytes)
    typedef enum logic [SCALE_W-1:0] {
        SCALE_B = 2'd0,
        SCALE_W2 = 2'd1,
        SCALE_L = 2'd2,
        SCALE_Q = 2'd3
    } scale_e;

    // Per-request control that travels down the pipe with the data
    typedef struct packed {
        logic   zext;
        scale_e scale;
        logic   jq;
    } ctl_t;

    // Divide the byte difference by the element size; sign-extending
    // requests keep a negative difference negative.
    function automatic logic [INDEX_W-1:0] scale_index(
        input logic [INDEX_W-1:0] diff,
        input scale_e             scale,
        input logic               zext
    );
        logic [INDEX_W-1:0] res;
        if (zext) res = diff >> scale;
        else      res = $unsigned($signed(diff) >>> scale);
        return res;
    endfunction

    // Any byte offset left over below the element size
    function automatic logic low_bits_set(
        input logic [INDEX_W-1:0] diff,
        input scale_e             scale
    );
        logic [INDEX_W-1:0] mask;
        mask = (INDEX_W'(1) << scale) - INDEX_W'(1);
        return |(diff & mask);
    endfunction

endpackage

// File: rtl/exagu_rev_slice.sv
// exagu_rev_slice: one 16-bit slice of the split address subtraction,
// a - b - borrow_in, producing the slice difference and its borrow out.
module exagu_rev_slice
    import exagu_rev_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_bin,
    output logic [SLICE_W-1:0] o_d,
    output logic               o_bout
);

    logic [SLICE_W:0] w_diff;

    // The extra top bit goes to 1 exactly when the slice result underflows
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{SLICE_W{1'b0}}, i_bin};
    assign o_d    = w_diff[SLICE_W-1:0];
    assign o_bout = w_diff[SLICE_W];

endmodule

// File: rtl/exagu_rev_index.sv
// exagu_rev_index: reverse AGU, index = (addr - base) >> scale.
// Three-stage pipeline, one 16-bit subtraction slice per stage, with a
// shared advance enable so the whole pipe stalls as a unit.
// Optional build macro: EXAGU_REV_BOUNDS_EN adds regValLimit/outBndFault.
module exagu_rev_index
    import exagu_rev_pkg::*;
#(
    parameter int ADDR_W = 48
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [ADDR_W-1:0] regValAddr,
    input  logic [ADDR_W-1:0] regValBase,
    input  logic [8:0]        idUIxt,
    input  logic              addrEnJq,
`ifdef EXAGU_REV_BOUNDS_EN
    input  logic [ADDR_W-1:0] regValLimit,
    output logic              outBndFault,
`endif
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] regOutIndex,
    output logic              outMisalign
);

    localparam int HI_W = ADDR_W - SLICE_W;

    logic w_adv;
    ctl_t w_ctl_in;
    logic w_unused_uixt;

    // Stage 1 registers
    logic               r_s1_valid;
    logic [SLICE_W-1:0] r_s1_d0;
    logic               r_s1_b0;
    logic [HI_W-1:0]    r_s1_addr_hi;
    logic [HI_W-1:0]    r_s1_base_hi;
    ctl_t               r_s1_ctl;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [SLICE_W-1:0] r_s2_d0;
    logic [SLICE_W-1:0] r_s2_d1;
    logic               r_s2_b1;
    logic [SLICE_W-1:0] r_s2_addr_top;
    logic [SLICE_W-1:0] r_s2_base_top;
    ctl_t               r_s2_ctl;

    // Stage 3 (output) registers
    logic               r_s3_valid;
    logic [ADDR_W-1:0]  r_out_index;
    logic               r_out_misalign;

    // Slice results
    logic [SLICE_W-1:0] w_d0;
    logic               w_b0;
    logic [SLICE_W-1:0] w_d1;
    logic               w_b1;
    logic [SLICE_W-1:0] w_d2_sub;
    logic               w_b2_unused;

    // Output-stage combinational results
    logic [SLICE_W-1:0] w_d2;
    logic [ADDR_W-1:0]  w_diff;
    logic [ADDR_W-1:0]  w_index;
    logic               w_misalign;

    // A full output register blocks everything behind it
    assign w_adv    = !r_s3_valid || outReady;
    assign inReady  = w_adv;
    assign outValid = r_s3_valid;
    assign regOutIndex = r_out_index;
    assign outMisalign = r_out_misalign;

    // idUIxt[8:3] carry no meaning for this unit
    assign w_unused_uixt = ^idUIxt[UIXT_W-1:3];

    // Decode request control fields
    always_comb begin
        w_ctl_in.zext  = idUIxt[UIXT_ZEXT_BIT];
        w_ctl_in.scale = scale_e'(idUIxt[UIXT_SCALE_LSB +: SCALE_W]);
        w_ctl_in.jq    = addrEnJq;
    end

    exagu_rev_slice u_slice0 (
        .i_a    (regValAddr[SLICE_W-1:0]),
        .i_b    (regValBase[SLICE_W-1:0]),
        .i_bin  (1'b0),
        .o_d    (w_d0),
        .o_bout (w_b0)
    );

    exagu_rev_slice u_slice1 (
        .i_a    (r_s1_addr_hi[SLICE_W-1:0]),
        .i_b    (r_s1_base_hi[SLICE_W-1:0]),
        .i_bin  (r_s1_b0),
        .o_d    (w_d1),
        .o_bout (w_b1)
    );

    exagu_rev_slice u_slice2 (
        .i_a    (r_s2_addr_top),
        .i_b    (r_s2_base_top),
        .i_bin  (r_s2_b1),
        .o_d    (w_d2_sub),
        .o_bout (w_b2_unused)
    );

    // Stage 3 combinational: top slice select, scaling and misalignment
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_d2 = w_d2_sub;
        if (!r_s2_ctl.jq) begin
            w_d2 = r_s2_ctl.zext ? '0 : {SLICE_W{r_s2_d1[SLICE_W-1]}};
        end
        w_diff     = {w_d2, r_s2_d1, r_s2_d0};
        w_index    = scale_index(w_diff, r_s2_ctl.scale, r_s2_ctl.zext);
        w_misalign = low_bits_set(w_diff, r_s2_ctl.scale);
    end

    // Stage 1: low slice difference plus the operands still to be subtracted
    // NOTE: state is written with non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_d0      <= '0;
            r_s1_b0      <= 1'b0;
            r_s1_addr_hi <= '0;
            r_s1_base_hi <= '0;
            r_s1_ctl     <= '0;
        end else if (w_adv) begin
            r_s1_valid   <= inValid;
            r_s1_d0      <= w_d0;
            r_s1_b0      <= w_b0;
            r_s1_addr_hi <= regValAddr[ADDR_W-1:SLICE_W];
            r_s1_base_hi <= regValBase[ADDR_W-1:SLICE_W];
            r_s1_ctl     <= w_ctl_in;
        end
    end

    // Stage 2: middle slice difference and borrow into the top slice
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid    <= 1'b0;
            r_s2_d0       <= '0;
            r_s2_d1       <= '0;
            r_s2_b1       <= 1'b0;
            r_s2_addr_top <= '0;
            r_s2_base_top <= '0;
            r_s2_ctl      <= '0;
        end else if (w_adv) begin
            r_s2_valid    <= r_s1_valid;
            r_s2_d0       <= r_s1_d0;
            r_s2_d1       <= w_d1;
            r_s2_b1       <= w_b1;
            r_s2_addr_top <= r_s1_addr_hi[HI_W-1:SLICE_W];
            r_s2_base_top <= r_s1_base_hi[HI_W-1:SLICE_W];
            r_s2_ctl      <= r_s1_ctl;
        end
    end

    // Stage 3: registered index and misalignment flag, held while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s3_valid     <= 1'b0;
            r_out_index    <= '0;
            r_out_misalign <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid     <= r_s2_valid;
            r_out_index    <= w_index;
            r_out_misalign <= w_misalign;
        end
    end

`ifdef EXAGU_REV_BOUNDS_EN
    logic [ADDR_W-1:0] r_s1_limit;
    logic [ADDR_W-1:0] r_s2_limit;
    logic              r_out_bnd;
    logic              w_bnd;

    assign outBndFault = r_out_bnd;

    // Index at or past the limit, compared with the request's signedness
    always_comb begin
        w_bnd = 1'b0;
        if (r_s2_ctl.zext) w_bnd = (w_index >= r_s2_limit);
        else               w_bnd = ($signed(w_index) >= $signed(r_s2_limit));
    end

    // Limit travels with the request; fault flag lands with the index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_limit <= '0;
            r_s2_limit <= '0;
            r_out_bnd  <= 1'b0;
        end else if (w_adv) begin
            r_s1_limit <= regValLimit;
            r_s2_limit <= r_s1_limit;
            r_out_bnd  <= w_bnd;
        end
    end
`endif

endmodule

// File: tb/tb_exagu_rev_index.sv
// tb_exagu_rev_index: scoreboard bench for exagu_rev_index. The driver
// pushes the hand-computed result of each accepted request; a monitor pops
// and compares whenever a result is handed over (outValid && outReady).
module tb_exagu_rev_index;
    import exagu_rev_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [47:0] regValAddr = '0;
    logic [47:0] regValBase = '0;
    logic [8:0]  idUIxt = '0;
    logic        addrEnJq = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [47:0] regOutIndex;
    logic        outMisalign;
`ifdef EXAGU_REV_BOUNDS_EN
    logic [47:0] regValLimit = '0;
    logic        outBndFault;
`endif

    exagu_rev_index dut (
        .clock       (clock),
        .reset       (reset),
        .inValid     (inValid),
        .inReady     (inReady),
        .regValAddr  (regValAddr),
        .regValBase  (regValBase),
        .idUIxt      (idUIxt),
        .addrEnJq    (addrEnJq),
`ifdef EXAGU_REV_BOUNDS_EN
        .regValLimit (regValLimit),
        .outBndFault (outBndFault),
`endif
        .outValid    (outValid),
        .outReady    (outReady),
        .regOutIndex (regOutIndex),
        .outMisalign (outMisalign)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [47:0] idx;
        logic        mis;
        logic        bnd;
        logic        chk_lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    // 0: always ready, 1: ready pattern 1,0,0,1, 2: never ready
    int         rdy_mode = 0;
    logic [3:0] rdy_pat  = 4'b1001;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       outReady = 1'b1;
            1:       outReady = rdy_pat[cyc % 4];
            default: outReady = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake rule every cycle, scoreboard compare on hand-over
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            check("inReady", 48'(inReady), 48'(!outValid || outReady));
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 48'(outValid), 48'd0);
                end else begin
                    e = sb.pop_front();
                    check("index", regOutIndex, e.idx);
                    check("misalign", 48'(outMisalign), 48'(e.mis));
`ifdef EXAGU_REV_BOUNDS_EN
                    check("bnd_fault", 48'(outBndFault), 48'(e.bnd));
`endif
                    if (e.chk_lat) check("latency", 48'(cyc - e.acc), 48'd3);
                end
            end
        end
    end

    task automatic send(
        input logic [47:0] a,
        input logic [47:0] b,
        input scale_e      sc,
        input logic        zx,
        input logic        jq,
        input logic [47:0] lim,
        input logic [47:0] ei,
        input logic        em,
        input logic        eb,
        input logic        lat
    );
        exp_t e;
        bit   done = 0;
        regValAddr = a;
        regValBase = b;
        idUIxt     = {6'h2A, zx, sc};
        addrEnJq   = jq;
`ifdef EXAGU_REV_BOUNDS_EN
        regValLimit = lim;
`endif
        inValid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (inReady) begin
                e.idx = ei; e.mis = em; e.bnd = eb; e.chk_lat = lat; e.acc = cyc;
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: inReady stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clock);
            if (sb.size() == 0) done = 1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("reset_outValid", 48'(outValid), 48'd0);
        check("reset_index", regOutIndex, 48'd0);
        check("reset_misalign", 48'(outMisalign), 48'd0);
        check("reset_inReady", 48'(inReady), 48'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 0x1_0010 / 8 = 0x2002, empty pipe so latency is checked
        send(48'h0000_0001_0010, 48'h0, SCALE_Q, 1'b1, 1'b1, 48'h0,
             48'h0000_0000_2002, 1'b0, 1'b0, 1'b1);
        drain();

        // Directed cases, back-to-back
        send(48'h1004, 48'h1000, SCALE_L, 1'b1, 1'b1, 48'h0, 48'h1, 1'b0, 1'b0, 1'b0);
        send(48'h1006, 48'h1000, SCALE_L, 1'b1, 1'b1, 48'h0, 48'h1, 1'b1, 1'b0, 1'b0);
        send(48'h0001_0000_0000, 48'h1, SCALE_B, 1'b1, 1'b1, 48'h0,
             48'h0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(48'h0001_0000_0000, 48'h1, SCALE_B, 1'b0, 1'b0, 48'h0,
             48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(48'h0001_0000_0000, 48'h1, SCALE_B, 1'b1, 1'b0, 48'h0,
             48'h0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(48'h100, 48'h108, SCALE_Q, 1'b0, 1'b1, 48'h0,
             48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        // -16 halved: arithmetic vs logical, plus a misaligned negative
        send(48'h0, 48'h10, SCALE_W2, 1'b0, 1'b1, 48'h0,
             48'hFFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0);
        send(48'h0, 48'h10, SCALE_W2, 1'b1, 1'b1, 48'h0,
             48'h7FFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0);
        send(48'h0, 48'h3, SCALE_L, 1'b0, 1'b1, 48'h0,
             48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
`ifdef EXAGU_REV_BOUNDS_EN
        send(48'h5, 48'h0, SCALE_B, 1'b1, 1'b1, 48'h5, 48'h5, 1'b0, 1'b1, 1'b0);
        send(48'h5, 48'h0, SCALE_B, 1'b1, 1'b1, 48'h6, 48'h5, 1'b0, 1'b0, 1'b0);
        send(48'h0, 48'h1, SCALE_B, 1'b0, 1'b1, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(48'h0, 48'h1, SCALE_B, 1'b1, 1'b1, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
`endif
        drain();

        // Stream of 8 with a stalling consumer: index i, in order
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send(48'h2000 + 48'(4 * i), 48'h2000, SCALE_L, 1'b1, 1'b1, 48'h0,
                 48'(i), 1'b0, 1'b0, 1'b0);
        end
        drain();
        rdy_mode = 0;
        @(posedge clock);
        #1;

        // Reset with three requests in flight
        rdy_mode = 2;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            send(48'h3000 + 48'(i), 48'h3000, SCALE_B, 1'b1, 1'b1, 48'h0,
                 48'(i), 1'b0, 1'b0, 1'b0);
        end
        @(posedge clock);
        #3;
        check("prereset_outValid", 48'(outValid), 48'd1);
        reset = 1'b0;
        #1;
        check("async_reset_outValid", 48'(outValid), 48'd0);
        check("async_reset_index", regOutIndex, 48'd0);
        sb.delete();
        rdy_mode = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("post_reset_outValid", 48'(outValid), 48'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
